// File: rtl/csel_pkg.sv
// csel_pkg: shared constants, stage count helper and stage record for csel_pipe_adder (CSEL_OVF_EN adds sign bits)
package csel_pkg;

  localparam int CSEL_WIDTH = 32;
  localparam int CSEL_BLK   = 8;

  function automatic int csel_nblk(input int width, input int blk);
    return width / blk;
  endfunction

  typedef struct packed {
    logic                  v;
    logic [CSEL_WIDTH-1:0] s;
    logic                  c;
    logic [CSEL_WIDTH-1:0] a;
    logic [CSEL_WIDTH-1:0] b;
`ifdef CSEL_OVF_EN
    logic                  sa;
    logic                  sb;
`endif
  } csel_stage_t;

endpackage

// File: rtl/csel_block.sv
// csel_block: combinational carry-select block, two ripple chains (carry 0 / carry 1) and a late select
module csel_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           c_i,
  output logic [BLK-1:0] s_o,
  output logic           c_o
);

  logic [BLK-1:0] s0, s1;
  logic           k0, k1;

  // both ripple chains are evaluated up front so only the select waits on the incoming carry
  always_comb begin
    s0 = '0;
    s1 = '0;
    k0 = 1'b0;
    k1 = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      s0[i] = a_i[i] ^ b_i[i] ^ k0;
      k0    = (a_i[i] & b_i[i]) | (k0 & (a_i[i] ^ b_i[i]));
      s1[i] = a_i[i] ^ b_i[i] ^ k1;
      k1    = (a_i[i] & b_i[i]) | (k1 & (a_i[i] ^ b_i[i]));
    end
  end

  assign s_o = c_i ? s1 : s0;
  assign c_o = c_i ? k1 : k0;

endmodule

// File: rtl/csel_pipe_adder.sv
// csel_pipe_adder: NBLK-stage carry-select pipelined adder with valid/ready flow control; CSEL_OVF_EN adds signed-overflow output ovf
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH,
  parameter int BLK   = CSEL_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = csel_nblk(WIDTH, BLK);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] s;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef CSEL_OVF_EN
    logic             sa;
    logic             sb;
`endif
  } stage_t;

  stage_t st_q [NBLK];
  logic   stall;

  assign stall     = st_q[NBLK-1].v && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = st_q[NBLK-1].v;
  assign sum       = {st_q[NBLK-1].c, st_q[NBLK-1].s};

`ifdef CSEL_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    stage_t         prev, d;
    logic [BLK-1:0] bs;
    logic           bc;
    if (k == 0) begin : g_first
      // stage 0 takes the raw beat; cin plays the role of the previous block carry
      always_comb begin
        prev   = '0;
        prev.v = in_valid;
        prev.c = cin;
        prev.a = a;
        prev.b = b;
`ifdef CSEL_OVF_EN
        prev.sa = a[WIDTH-1];
        prev.sb = b[WIDTH-1];
`endif
      end
    end else begin : g_next
      assign prev = st_q[k-1];
    end
    csel_block #(.BLK(BLK)) u_blk (
      .a_i(prev.a[BLK-1:0]),
      .b_i(prev.b[BLK-1:0]),
      .c_i(prev.c),
      .s_o(bs),
      .c_o(bc)
    );
    // resolve this block; unresolved operand bits shift down so every stage consumes the low BLK bits
    always_comb begin
      d                   = prev;
      d.s[k*BLK +: BLK]   = bs;
      d.c                 = bc;
      d.a                 = prev.a >> BLK;
      d.b                 = prev.b >> BLK;
    end
    // whole pipeline advances together and freezes while the output is stalled
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st_q[k] <= '0;
      else if (!stall) st_q[k] <= d;
`ifdef CSEL_OVF_EN
    if (k == NBLK - 1) begin : g_ovf
      // overflow is decided from the carried sign bits and the final sum MSB
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_q <= 1'b0;
        else if (!stall) ovf_q <= (d.sa == d.sb) && (d.s[WIDTH-1] != d.sa);
    end
`endif
  end

endmodule

// File: tb/tb_csel_pipe_adder.sv
// tb_csel_pipe_adder: directed self-checking bench for csel_pipe_adder at 32/8, 16/4 and 8/8 (CSEL_OVF_EN adds overflow checks)
module tb_csel_pipe_adder;

  logic clk, rst_n;
  logic [31:0] a0, b0;
  logic        cin0, iv0, ir0, ov0, or0;
  logic [32:0] s0;
  logic [15:0] a1, b1;
  logic        cin1, iv1, ir1, ov1, or1;
  logic [16:0] s1;
  logic [7:0]  a2, b2;
  logic        cin2, iv2, ir2, ov2, or2;
  logic [8:0]  s2;
`ifdef CSEL_OVF_EN
  logic        ovf0, ovf1, ovf2;
`endif
  int checks = 0;
  int errors = 0;

  csel_pipe_adder u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0),
    .out_valid(ov0), .out_ready(or0), .sum(s0)
`ifdef CSEL_OVF_EN
    , .ovf(ovf0)
`endif
  );

  csel_pipe_adder #(.WIDTH(16), .BLK(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1)
`ifdef CSEL_OVF_EN
    , .ovf(ovf1)
`endif
  );

  csel_pipe_adder #(.WIDTH(8), .BLK(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
    .out_valid(ov2), .out_ready(or2), .sum(s2)
`ifdef CSEL_OVF_EN
    , .ovf(ovf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    iv0 = 0; iv1 = 0; iv2 = 0; or0 = 1; or1 = 1; or2 = 1;
    a0 = 0; b0 = 0; cin0 = 0; a1 = 0; b1 = 0; cin1 = 0; a2 = 0; b2 = 0; cin2 = 0;
    tick;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
    checks++; if (s0 !== 33'h0) begin errors++; $display("FAIL reset_sum got %h want 0", s0); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir0); end
    checks++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin errors++; $display("FAIL reset_small_valid got %b%b want 00", ov1, ov2); end
`ifdef CSEL_OVF_EN
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf0); end
`endif
    #3 rst_n = 1'b1;
    tick;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", ir0); end
  endtask

  task automatic test_latency;
    a0 = 32'hFFFFFFFF; b0 = 32'h1; cin0 = 0; iv0 = 1;
    a1 = 16'hFFFF; b1 = 16'h0; cin1 = 1; iv1 = 1;
    a2 = 8'hFF; b2 = 8'h0; cin2 = 1; iv2 = 1;
    for (int n = 1; n <= 6; n++) begin
      tick;
      iv0 = 0; iv1 = 0; iv2 = 0;
      checks++; if (ov0 !== (n == 4)) begin errors++; $display("FAIL lat32_valid cycle %0d got %b want %b", n, ov0, n == 4); end
      checks++; if (ov1 !== (n == 4)) begin errors++; $display("FAIL lat16_valid cycle %0d got %b want %b", n, ov1, n == 4); end
      checks++; if (ov2 !== (n == 1)) begin errors++; $display("FAIL lat8_valid cycle %0d got %b want %b", n, ov2, n == 1); end
      if (n == 4) begin
        checks++; if (s0 !== 33'h1_0000_0000) begin errors++; $display("FAIL lat32_sum got %h want 100000000", s0); end
        checks++; if (s1 !== 17'h1_0000) begin errors++; $display("FAIL lat16_sum got %h want 10000", s1); end
      end
      if (n == 1) begin
        checks++; if (s2 !== 9'h100) begin errors++; $display("FAIL lat8_sum got %h want 100", s2); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] q[$];
    logic [32:0] e;
    int sent, rcv, cyc;
    sent = 0; rcv = 0; cyc = 0; or0 = 1;
    while (rcv < 100 && cyc < 400) begin
      if (ov0) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got %h want no beat", s0);
        end else begin
          e = q.pop_front();
          if (s0 !== e) begin errors++; $display("FAIL b2b_sum beat %0d got %h want %h", rcv, s0, e); end
        end
        rcv++;
      end
      checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", cyc, ir0); end
      if (sent < 100) begin
        a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom_range(1, 0)); iv0 = 1;
        q.push_back({1'b0, a0} + {1'b0, b0} + 33'(cin0));
        sent++;
      end else iv0 = 0;
      tick;
      cyc++;
    end
    iv0 = 0;
    checks++; if (rcv !== 100) begin errors++; $display("FAIL b2b_count got %0d want 100", rcv); end
  endtask

  task automatic test_stall;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vc [4];
    logic [32:0] ve [4];
    int rcv;
    va = '{32'h12345678, 32'h80000000, 32'h000000FF, 32'hFFFF0000};
    vb = '{32'h11111111, 32'h80000000, 32'h00000001, 32'h0000FFFF};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1};
    ve = '{33'h0_23456789, 33'h1_00000001, 33'h0_00000100, 33'h1_00000000};
    or0 = 0;
    for (int i = 0; i < 4; i++) begin
      a0 = va[i]; b0 = vb[i]; cin0 = vc[i]; iv0 = 1;
      checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL stall_fill_ready beat %0d got %b want 1", i, ir0); end
      tick;
    end
    a0 = 32'hDEADBEEF; b0 = 32'h1; cin0 = 0; iv0 = 1;
    for (int n = 0; n < 6; n++) begin
      checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want 0", n, ir0); end
      checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d got %b want 1", n, ov0); end
      checks++; if (s0 !== ve[0]) begin errors++; $display("FAIL stall_sum_hold cycle %0d got %h want %h", n, s0, ve[0]); end
      if (n < 5) tick;
    end
    or0 = 1; iv0 = 0;
    rcv = 1;
    for (int n = 0; n < 8; n++) begin
      tick;
      if (ov0) begin
        checks++;
        if (rcv >= 4) begin errors++; $display("FAIL stall_extra got %h want no beat", s0); end
        else if (s0 !== ve[rcv]) begin errors++; $display("FAIL stall_order beat %0d got %h want %h", rcv, s0, ve[rcv]); end
        rcv++;
      end
    end
    checks++; if (rcv !== 4) begin errors++; $display("FAIL stall_count got %0d want 4", rcv); end
  endtask

  task automatic test_reset_midflight;
    or0 = 1;
    for (int i = 0; i < 3; i++) begin
      a0 = 32'h100 * (i + 1); b0 = 32'h3; cin0 = 0; iv0 = 1;
      tick;
    end
    iv0 = 0;
    tick;
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL mid_first_valid got %b want 1", ov0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", ov0); end
    checks++; if (s0 !== 33'h0) begin errors++; $display("FAIL mid_async_sum got %h want 0", s0); end
    #2 rst_n = 1'b1;
    tick;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", ir0); end
    a0 = 32'd5; b0 = 32'd7; cin0 = 1; iv0 = 1;
    for (int n = 1; n <= 6; n++) begin
      tick;
      iv0 = 0;
      checks++; if (ov0 !== (n == 4)) begin errors++; $display("FAIL mid_stale cycle %0d got %b want %b", n, ov0, n == 4); end
      if (n == 4) begin
        checks++; if (s0 !== 33'd13) begin errors++; $display("FAIL mid_sum got %h want d", s0); end
      end
    end
  endtask

`ifdef CSEL_OVF_EN
  task automatic test_ovf;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vo [3];
    va = '{32'h7FFFFFFF, 32'h80000000, 32'h00000005};
    vb = '{32'h00000001, 32'hFFFFFFFF, 32'h00000003};
    vo = '{1'b1, 1'b1, 1'b0};
    or0 = 1;
    for (int n = 0; n < 7; n++) begin
      if (n < 3) begin a0 = va[n]; b0 = vb[n]; cin0 = 0; iv0 = 1; end
      else iv0 = 0;
      tick;
      if (n >= 3 && n <= 5) begin
        checks++; if (ovf0 !== vo[n-3]) begin errors++; $display("FAIL ovf_flag beat %0d got %b want %b", n - 3, ovf0, vo[n-3]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_latency;
    test_back_to_back;
    test_stall;
    test_reset_midflight;
`ifdef CSEL_OVF_EN
    test_ovf;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
